// File: rtl/axil_sram_slave.sv
// axil_sram_slave
//   AXI4-Lite responder in front of a word-addressed on-chip SRAM. The read
//   and write channels run independent FSMs. Each FSM keeps one transaction
//   outstanding and inserts a programmable number of wait cycles to model
//   slow memory. Addresses outside the SRAM window return DECERR.
//
// Parameters
//   BASE_ADDR   byte address of word 0
//   DEPTH_WORDS number of 32-bit words (power of 2)
//   RD_LATENCY  wait cycles between AR handshake and rvalid (0..15)
//   WR_LATENCY  wait cycles between AW+W capture and bvalid (0..15)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel (rresp 00 OKAY, 11 DECERR)
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel (wstrb bit i -> byte i)
//   bresp/bvalid/bready           write response channel (00 OKAY, 11 DECERR)
module axil_sram_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          RD_LATENCY  = 2,
   parameter int          WR_LATENCY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  RD_LAT   = 4'(RD_LATENCY);
   localparam logic [3:0]  WR_LAT   = 4'(WR_LATENCY);
   localparam logic [1:0]  OKAY     = 2'b00;
   localparam logic [1:0]  DECERR   = 2'b11;

   // Window check done in 33 bits so the top of the window cannot wrap.
   function automatic logic in_range(input logic [31:0] a);
      return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   logic [31:0] mem [DEPTH_WORDS];

   // ---------------- read channel ----------------
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;
   rstate_e     rstate_q, rstate_d;
   logic [3:0]  rcnt_q, rcnt_d;
   logic [31:0] raddr_q, raddr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rd_addr;
   logic        r_sample;

   always_comb begin
      rstate_d = rstate_q;
      rcnt_d   = rcnt_q;
      raddr_d  = raddr_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rd_addr  = raddr_q;
      r_sample = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            // With zero latency the sample uses the address on the bus.
            rd_addr = araddr;
            if (arvalid) begin
               raddr_d = araddr;
               rcnt_d  = RD_LAT;
               if (RD_LATENCY == 0) begin
                  rstate_d = R_RESP;
                  r_sample = 1'b1;
               end else begin
                  rstate_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            rcnt_d = rcnt_q - 4'd1;
            if (rcnt_q <= 4'd1) begin
               rstate_d = R_RESP;
               r_sample = 1'b1;
            end
         end
         R_RESP: if (rready) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
      // The memory array still holds pre-commit data on a shared edge,
      // so a simultaneous write is not visible to this sample.
      if (r_sample) begin
         if (in_range(rd_addr)) begin
            rdata_d = mem[word_idx(rd_addr)];
            rresp_d = OKAY;
         end else begin
            rdata_d = '0;
            rresp_d = DECERR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rstate_q <= R_IDLE;
      else     rstate_q <= rstate_d;
      rcnt_q  <= rcnt_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
   end

   assign arready = !rst && (rstate_q == R_IDLE);
   assign rvalid  = !rst && (rstate_q == R_RESP);
   assign rdata   = rst ? '0 : rdata_q;
   assign rresp   = rst ? '0 : rresp_q;

   // ---------------- write channel ----------------
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;
   wstate_e     wstate_q, wstate_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   logic        w_commit;

   always_comb begin
      wstate_d = wstate_q;
      wcnt_d   = wcnt_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      bresp_d  = bresp_q;
      w_commit = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (!aw_got_q && awvalid) begin
               aw_got_d = 1'b1;
               awaddr_d = awaddr;
            end
            if (!w_got_q && wvalid) begin
               w_got_d = 1'b1;
               wdata_d = wdata;
               wstrb_d = wstrb;
            end
            if (aw_got_d && w_got_d) begin
               wcnt_d = WR_LAT;
               if (WR_LATENCY == 0) begin
                  wstate_d = W_RESP;
                  w_commit = 1'b1;
               end else begin
                  wstate_d = W_WAIT;
               end
            end
         end
         W_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q <= 4'd1) begin
               wstate_d = W_RESP;
               w_commit = 1'b1;
            end
         end
         W_RESP: begin
            if (bready) begin
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               wstate_d = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
      // Next-state capture values double as the commit operands so that a
      // zero-latency write can commit on the capture edge itself.
      wr_addr = awaddr_d;
      wr_data = wdata_d;
      wr_strb = wstrb_d;
      if (w_commit) bresp_d = in_range(wr_addr) ? OKAY : DECERR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate_q <= W_IDLE;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
      end else begin
         wstate_q <= wstate_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
      end
      wcnt_q   <= wcnt_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
   end

   // Reset suppresses the commit so an in-flight write is dropped cleanly.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && in_range(wr_addr)) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign awready = !rst && (wstate_q == W_IDLE) && !aw_got_q;
   assign wready  = !rst && (wstate_q == W_IDLE) && !w_got_q;
   assign bvalid  = !rst && (wstate_q == W_RESP);
   assign bresp   = rst ? '0 : bresp_q;

endmodule
